cla_result_accumulator: RTL and testbench

- Downstream consumer of the 4-bit carry lookahead adder.
- Takes the adder's 5-bit result (carry plus 4-bit sum) through a valid/ready handshake.
- Accumulates NUM_SAMPLES results into a wider register and presents the total as a frame, held until the receiver accepts it.
- Sticky overflow flag reports accumulator wrap.

---
 rtl/cla_result_accumulator_if.sv | 43 ++++
 rtl/cla_result_accumulator.sv | 96 +++++++++
 tb/tb_cla_result_accumulator.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_result_accumulator_if.sv
// Handshake bundle between the CLA result producer, the accumulator and the
// frame receiver. The accumulator attaches through the slave modport; the
// producer/receiver side uses the master modport.
interface cla_result_accumulator_if #(
    parameter int ACC_WIDTH   = 8,
    parameter int NUM_SAMPLES = 8
);
    localparam int CNT_WIDTH = $clog2(NUM_SAMPLES) + 1;

    logic                 i_clear;
    logic [4:0]           i_result;
    logic                 i_result_valid;
    logic                 o_result_ready;
    logic [ACC_WIDTH-1:0] o_sum;
    logic                 o_overflow;
    logic [CNT_WIDTH-1:0] o_count;
    logic                 o_sum_valid;
    logic                 i_sum_ready;

    modport slave (
        input  i_clear,
        input  i_result,
        input  i_result_valid,
        output o_result_ready,
        output o_sum,
        output o_overflow,
        output o_count,
        output o_sum_valid,
        input  i_sum_ready
    );

    modport master (
        output i_clear,
        output i_result,
        output i_result_valid,
        input  o_result_ready,
        input  o_sum,
        input  o_overflow,
        input  o_count,
        input  o_sum_valid,
        output i_sum_ready
    );
endinterface

// File: rtl/cla_result_accumulator.sv
// Sums NUM_SAMPLES unsigned 5-bit CLA results per frame into an ACC_WIDTH
// accumulator that wraps, with a sticky wrap flag. A finished frame is held
// on the outputs until the receiver takes it; i_clear aborts a frame.
module cla_result_accumulator #(
    parameter int NUM_SAMPLES = 8,
    parameter int ACC_WIDTH   = 8
) (
    input logic                     i_clk,
    input logic                     i_rst,
    cla_result_accumulator_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(NUM_SAMPLES) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_SAMPLES - 1);

    typedef enum logic {
        S_ACCUM  = 1'b0,
        S_OUTPUT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ready;
    logic                 accept;
    logic [ACC_WIDTH:0]   sum_ext;

    // Wrapping add; the extra top bit is the carry out of the accumulator.
    function automatic logic [ACC_WIDTH:0] acc_add(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [4:0]           res
    );
        return {1'b0, acc} + {{(ACC_WIDTH-4){1'b0}}, res};
    endfunction

    assign ready   = (state_q == S_ACCUM) & ~bus.i_clear;
    assign accept  = bus.i_result_valid & ready;
    assign sum_ext = acc_add(acc_q, bus.i_result);

    // Next-state: clear beats everything, then accumulate or hand off the frame.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (bus.i_clear) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        acc_d = sum_ext[ACC_WIDTH-1:0];
                        ovf_d = ovf_q | sum_ext[ACC_WIDTH];
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = S_OUTPUT;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (bus.i_sum_ready) begin
                        state_d = S_ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = S_ACCUM;
            endcase
        end
    end

    // State and frame registers; reset drops any pending frame immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_result_ready = ready;
    assign bus.o_sum          = acc_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_count        = cnt_q;
    assign bus.o_sum_valid    = (state_q == S_OUTPUT);
endmodule

// File: tb/tb_cla_result_accumulator.sv
// Bench for cla_result_accumulator: default-size instance with a reference
// model and frame scoreboard, plus a narrow instance for the wrap case.
module tb_cla_result_accumulator;
    logic clk;
    logic rst;

    cla_result_accumulator_if #(.ACC_WIDTH(8), .NUM_SAMPLES(8)) bus_a ();
    cla_result_accumulator_if #(.ACC_WIDTH(5), .NUM_SAMPLES(2)) bus_b ();

    cla_result_accumulator #(.NUM_SAMPLES(8), .ACC_WIDTH(8)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    cla_result_accumulator #(.NUM_SAMPLES(2), .ACC_WIDTH(5)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    typedef struct {
        int sum;
        int ovf;
        int cnt;
    } frame_t;

    frame_t exp_q[$];

    // Reference model of instance A (8 samples, 8-bit accumulator)
    int m_acc = 0;
    int m_cnt = 0;
    int m_ovf = 0;
    bit m_out = 1'b0;
    bit chk_en = 1'b0;
    bit seen = 1'b0;
    int frames = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_out = 1'b0;
            exp_q.delete();
        end else if (bus_a.i_clear) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_out = 1'b0;
        end else if (m_out) begin
            if (bus_a.i_sum_ready) begin
                m_acc = 0; m_cnt = 0; m_ovf = 0; m_out = 1'b0;
            end
        end else if (bus_a.i_result_valid) begin
            m_acc = m_acc + int'(bus_a.i_result);
            m_cnt = m_cnt + 1;
            if (m_acc >= 256) begin
                m_acc = m_acc - 256;
                m_ovf = 1;
            end
            if (m_cnt == 8) begin
                frame_t f;
                m_out = 1'b1;
                f.sum = m_acc; f.ovf = m_ovf; f.cnt = m_cnt;
                exp_q.push_back(f);
            end
        end
    end

    // Per-cycle comparison against the model, frames popped from the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", int'(bus_a.o_result_ready), int'(!m_out && !bus_a.i_clear));
            check("sum_valid", int'(bus_a.o_sum_valid), int'(m_out));
            check("sum", int'(bus_a.o_sum), m_acc);
            check("count", int'(bus_a.o_count), m_cnt);
            check("overflow", int'(bus_a.o_overflow), m_ovf);
            if (bus_a.o_sum_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("sb_pending", exp_q.size(), 1);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    frames++;
                    check("sb_sum", int'(bus_a.o_sum), f.sum);
                    check("sb_ovf", int'(bus_a.o_overflow), f.ovf);
                    check("sb_cnt", int'(bus_a.o_count), f.cnt);
                end
            end
            if (!bus_a.o_sum_valid) seen = 1'b0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] r);
        bus_a.i_result_valid = v;
        bus_a.i_result       = r;
    endtask

    int gap_v[7] = '{1, 0, 1, 1, 0, 0, 1};
    int gap_d[7] = '{3, 31, 4, 5, 17, 29, 6};

    initial begin
        int run;
        rst = 1'b1;
        bus_a.i_clear = 1'b0; bus_a.i_result = '0; bus_a.i_result_valid = 1'b0; bus_a.i_sum_ready = 1'b0;
        bus_b.i_clear = 1'b0; bus_b.i_result = '0; bus_b.i_result_valid = 1'b0; bus_b.i_sum_ready = 1'b0;

        // Reset held for three cycles
        repeat (3) cycle();
        rst = 1'b0;
        #1;
        check("rst_sum", int'(bus_a.o_sum), 0);
        check("rst_count", int'(bus_a.o_count), 0);
        check("rst_ovf", int'(bus_a.o_overflow), 0);
        check("rst_valid", int'(bus_a.o_sum_valid), 0);
        check("rst_ready", int'(bus_a.o_result_ready), 1);
        check("rst_ready_b", int'(bus_b.o_result_ready), 1);
        chk_en = 1'b1;

        // Eight back-to-back 31s, receiver always ready
        bus_a.i_sum_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 5'd31);
            cycle();
        end
        drive_a(1'b0, 5'd0);
        check("full_valid", int'(bus_a.o_sum_valid), 1);
        check("full_sum", int'(bus_a.o_sum), 248);
        check("full_ovf", int'(bus_a.o_overflow), 0);
        check("full_count", int'(bus_a.o_count), 8);
        cycle();
        check("full_after_sum", int'(bus_a.o_sum), 0);
        check("full_after_ready", int'(bus_a.o_result_ready), 1);

        // Narrow instance: 20 + 20 wraps a 5-bit accumulator
        bus_b.i_result_valid = 1'b1;
        bus_b.i_result = 5'd20;
        cycle();
        cycle();
        bus_b.i_result_valid = 1'b0;
        check("wrap_valid", int'(bus_b.o_sum_valid), 1);
        check("wrap_sum", int'(bus_b.o_sum), 8);
        check("wrap_ovf", int'(bus_b.o_overflow), 1);
        check("wrap_count", int'(bus_b.o_count), 2);
        bus_b.i_sum_ready = 1'b1;
        cycle();
        check("wrap_after_valid", int'(bus_b.o_sum_valid), 0);
        check("wrap_after_sum", int'(bus_b.o_sum), 0);
        check("wrap_after_ovf", int'(bus_b.o_overflow), 0);
        bus_b.i_sum_ready = 1'b0;

        // Backpressure: frame 1..8 held while 9s are offered
        bus_a.i_sum_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive_a(1'b1, 5'(i));
            cycle();
        end
        drive_a(1'b1, 5'd9);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_valid", int'(bus_a.o_sum_valid), 1);
            check("bp_sum", int'(bus_a.o_sum), 36);
            check("bp_ready", int'(bus_a.o_result_ready), 0);
            check("bp_count", int'(bus_a.o_count), 8);
        end
        bus_a.i_sum_ready = 1'b1;
        cycle();
        check("bp_rel_valid", int'(bus_a.o_sum_valid), 0);
        check("bp_rel_sum", int'(bus_a.o_sum), 0);
        cycle();
        check("bp_nine_sum", int'(bus_a.o_sum), 9);
        check("bp_nine_count", int'(bus_a.o_count), 1);
        drive_a(1'b0, 5'd0);
        bus_a.i_clear = 1'b1;
        cycle();
        bus_a.i_clear = 1'b0;

        // Gapped valid pattern
        run = 0;
        for (int i = 0; i < 7; i++) begin
            drive_a(gap_v[i] != 0, 5'(gap_d[i]));
            cycle();
            if (gap_v[i] != 0) run = run + gap_d[i];
            check("gap_sum", int'(bus_a.o_sum), run);
        end
        drive_a(1'b0, 5'd0);
        check("gap_count", int'(bus_a.o_count), 4);
        check("gap_total", int'(bus_a.o_sum), 18);
        bus_a.i_clear = 1'b1;
        cycle();
        bus_a.i_clear = 1'b0;

        // Clear with a valid sample in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 5'd5);
            cycle();
        end
        check("clr_pre_sum", int'(bus_a.o_sum), 15);
        drive_a(1'b1, 5'd7);
        bus_a.i_clear = 1'b1;
        #1;
        check("clr_ready", int'(bus_a.o_result_ready), 0);
        cycle();
        bus_a.i_clear = 1'b0;
        drive_a(1'b0, 5'd0);
        check("clr_sum", int'(bus_a.o_sum), 0);
        check("clr_count", int'(bus_a.o_count), 0);
        cycle();
        check("clr_no7", int'(bus_a.o_sum), 0);

        // Asynchronous reset while a frame is held
        bus_a.i_sum_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 5'd2);
            cycle();
        end
        drive_a(1'b0, 5'd0);
        cycle();
        check("arst_pre_valid", int'(bus_a.o_sum_valid), 1);
        check("arst_pre_sum", int'(bus_a.o_sum), 16);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", int'(bus_a.o_sum_valid), 0);
        check("arst_sum", int'(bus_a.o_sum), 0);
        check("arst_count", int'(bus_a.o_count), 0);
        check("arst_ovf", int'(bus_a.o_overflow), 0);
        check("arst_ready", int'(bus_a.o_result_ready), 1);
        #1;
        rst = 1'b0;
        cycle();
        check("arst_after_ready", int'(bus_a.o_result_ready), 1);

        check("sb_drained", exp_q.size(), 0);
        check("sb_frames", frames, 3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
